// File: rtl/tx_frame_scheduler_pkg.sv
// Shared types and defaults for the transmit frame scheduler.
package tx_frame_scheduler_pkg;

  localparam int DEFAULT_DATA_W        = 12;
  localparam int DEFAULT_FIFO_DEPTH    = 4;
  localparam int DEFAULT_BIT_CYCLES    = 256;
  localparam int DEFAULT_PREAMBLE_BITS = 4;
  localparam int DEFAULT_GUARD_BITS    = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_PREAMBLE = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_GUARD    = 3'd4
  } state_t;

  // Number of transmitted bits spent in a timed state; untimed states report 1
  // so that "bits - 1" never underflows.
  function automatic int unsigned bits_in_state(state_t s, int unsigned pre_bits,
                                                int unsigned data_bits, int unsigned guard_bits);
    int unsigned n;
    n = 1;
    case (s)
      ST_PREAMBLE: n = pre_bits;
      ST_PAYLOAD:  n = data_bits;
      ST_GUARD:    n = guard_bits;
      default:     n = 1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tx_frame_scheduler_fifo.sv
// Small synchronous FIFO with registered full/empty flags and an occupancy count.
// The head entry is visible on rd_data without a read latency.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_next;

  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign level_next = level + LW'(do_push) - LW'(do_pop);
  assign rd_data    = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, count and the pre-decoded flags so full/empty come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Buffers encoder codewords and serialises each one as preamble, payload (MSB
// first) and guard bits towards the BPSK modulator, one bit per BIT_CYCLES clocks.
module tx_frame_scheduler
  import tx_frame_scheduler_pkg::*;
#(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter int BIT_CYCLES    = DEFAULT_BIT_CYCLES,
  parameter int PREAMBLE_BITS = DEFAULT_PREAMBLE_BITS,
  parameter int GUARD_BITS    = DEFAULT_GUARD_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_W-1:0]             cw_data,
  input  logic                          cw_valid,
  output logic                          cw_ready,
  output logic                          mod_bit,
  output logic                          mod_en,
  output logic                          bit_strobe,
  output logic                          frame_start,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W = $clog2(DATA_W + PREAMBLE_BITS + GUARD_BITS + 1);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [CNT_W-1:0]  clk_cnt_next;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_cnt_next;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;

  logic              last_clk;
  logic              last_bit;
  int unsigned       state_bits;

  logic              mod_bit_d;
  logic              mod_en_d;
  logic              bit_strobe_d;
  logic              frame_start_d;
  logic              busy_d;

  // A word arriving while the FIFO is full is dropped; a pop in the same cycle
  // does not free the slot because ready is derived from the registered full flag.
  assign fifo_push = cw_valid && !fifo_full;
  assign fifo_pop  = (state == ST_LOAD);
  assign cw_ready  = !fifo_full;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (cw_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign state_bits = bits_in_state(state, PREAMBLE_BITS, DATA_W, GUARD_BITS);
  assign last_clk   = (clk_cnt == CNT_W'(BIT_CYCLES - 1));
  assign last_bit   = (bit_cnt == BIT_W'(state_bits - 1));

  // State, bit/clock counters and payload shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= next_state;
      clk_cnt   <= clk_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shift_reg <= shift_next;
    end
  end

  // Next state and counter updates; a timed state ends on the wrap of its last bit.
  always_comb begin
    next_state   = state;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_reg;
    case (state)
      ST_IDLE: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        if (en && !fifo_empty) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        clk_cnt_next = '0;
        bit_cnt_next = '0;
        shift_next   = fifo_rd_data;
        next_state   = ST_PREAMBLE;
      end
      ST_PREAMBLE, ST_PAYLOAD, ST_GUARD: begin
        if (last_clk) begin
          clk_cnt_next = '0;
          if (last_bit) begin
            bit_cnt_next = '0;
            case (state)
              ST_PREAMBLE: next_state = ST_PAYLOAD;
              ST_PAYLOAD:  next_state = ST_GUARD;
              default:     next_state = ST_IDLE;
            endcase
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
            if (state == ST_PAYLOAD) shift_next = shift_reg << 1;
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      default: begin
        next_state   = ST_IDLE;
        clk_cnt_next = '0;
        bit_cnt_next = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so they can be registered.
  always_comb begin
    mod_bit_d     = 1'b0;
    mod_en_d      = 1'b0;
    bit_strobe_d  = 1'b0;
    frame_start_d = (state == ST_LOAD) && (next_state == ST_PREAMBLE);
    busy_d        = (next_state != ST_IDLE);
    case (next_state)
      ST_PREAMBLE: begin
        mod_en_d     = 1'b1;
        mod_bit_d    = ~bit_cnt_next[0];
        bit_strobe_d = (clk_cnt_next == '0);
      end
      ST_PAYLOAD: begin
        mod_en_d     = 1'b1;
        mod_bit_d    = shift_next[DATA_W-1];
        bit_strobe_d = (clk_cnt_next == '0);
      end
      ST_GUARD: begin
        bit_strobe_d = (clk_cnt_next == '0);
      end
      default: begin
        mod_en_d = 1'b0;
      end
    endcase
  end

  // Registered outputs; overflow stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mod_bit     <= 1'b0;
      mod_en      <= 1'b0;
      bit_strobe  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      mod_bit     <= mod_bit_d;
      mod_en      <= mod_en_d;
      bit_strobe  <= bit_strobe_d;
      frame_start <= frame_start_d;
      busy        <= busy_d;
      overflow    <= overflow | (cw_valid & fifo_full);
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler with a short bit period.
// A frame-timeline model (position within the frame, queue of words) predicts every output.
module tb_tx_frame_scheduler;

  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int BC    = 4;
  localparam int PRE   = 4;
  localparam int GRD   = 2;
  localparam int FRAME = (PRE + DW + GRD) * BC;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] cw_data;
  logic          cw_valid;
  logic          cw_ready;
  logic          mod_bit;
  logic          mod_en;
  logic          bit_strobe;
  logic          frame_start;
  logic          busy;
  logic          overflow;
  logic [2:0]    fifo_level;

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  logic [DW-1:0] mq[$];
  int            pos = -1;
  logic [DW-1:0] cur_word = '0;
  logic          m_overflow = 1'b0;

  tx_frame_scheduler #(
    .DATA_W        (DW),
    .FIFO_DEPTH    (DEPTH),
    .BIT_CYCLES    (BC),
    .PREAMBLE_BITS (PRE),
    .GUARD_BITS    (GRD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cw_data     (cw_data),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .mod_bit     (mod_bit),
    .mod_en      (mod_en),
    .bit_strobe  (bit_strobe),
    .frame_start (frame_start),
    .busy        (busy),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle_no, observed, expected);
    end
  endtask

  // Model: pos=-1 idle, pos=0 load cycle, pos=1..FRAME the cycles of the frame.
  task automatic modelEdge();
    logic accept;
    if (rst) begin
      mq.delete();
      pos        = -1;
      m_overflow = 1'b0;
    end else begin
      accept = cw_valid && (mq.size() < DEPTH);
      if (cw_valid && (mq.size() >= DEPTH)) m_overflow = 1'b1;
      if (pos < 0) begin
        if (en && mq.size() > 0) pos = 0;
      end else if (pos == 0) begin
        cur_word = mq.pop_front();
        pos      = 1;
      end else if (pos == FRAME) begin
        pos = -1;
      end else begin
        pos++;
      end
      if (accept) mq.push_back(cw_data);
    end
  endtask

  // Compare every DUT output against the model's view of the current cycle.
  task automatic checkAll();
    int   k;
    int   b;
    logic e_bit;
    logic e_en;
    logic e_strobe;
    k        = pos - 1;
    b        = (pos >= 1) ? k / BC : 0;
    e_en     = (pos >= 1) && (b < PRE + DW);
    e_strobe = (pos >= 1) && (k % BC == 0);
    e_bit    = 1'b0;
    if (pos >= 1 && b < PRE)           e_bit = (b % 2 == 0);
    else if (pos >= 1 && b < PRE + DW) e_bit = cur_word[DW-1-(b-PRE)];
    checkOutput("cw_ready",    32'(cw_ready),    32'(mq.size() < DEPTH));
    checkOutput("fifo_level",  32'(fifo_level),  32'(mq.size()));
    checkOutput("overflow",    32'(overflow),    32'(m_overflow));
    checkOutput("busy",        32'(busy),        32'(pos >= 0));
    checkOutput("frame_start", 32'(frame_start), 32'(pos == 1));
    checkOutput("mod_en",      32'(mod_en),      32'(e_en));
    checkOutput("mod_bit",     32'(mod_bit),     32'(e_bit));
    checkOutput("bit_strobe",  32'(bit_strobe),  32'(e_strobe));
  endtask

  // Drive one cycle of inputs, clock it, update the model and check just after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic v, input logic [DW-1:0] d);
    rst      = r;
    en       = e;
    cw_valid = v;
    cw_data  = d;
    @(posedge clk);
    cycle_no++;
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic idleCycles(input logic e, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, e, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cw_valid = 1'b0; cw_data = '0;

    // Reset held for two cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // Single frame of 12'hA5C.
    applyStimulus(1'b0, 1'b1, 1'b1, 12'hA5C);
    idleCycles(1'b1, FRAME + 6);

    // Fill the FIFO with en low; the fifth word is dropped.
    for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, DW'(i));
    checkOutput("fill_level", 32'(fifo_level), 32'd4);
    checkOutput("fill_overflow", 32'(overflow), 32'd1);
    idleCycles(1'b1, 4 * (FRAME + 2) + 6);

    // Drop en in the middle of a payload with two words still queued.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, DW'(12'h3C0 + i));
    idleCycles(1'b1, 30);
    idleCycles(1'b0, FRAME + 10);
    checkOutput("hold_level", 32'(fifo_level), 32'd2);
    checkOutput("hold_busy", 32'(busy), 32'd0);
    idleCycles(1'b1, 2 * (FRAME + 2) + 4);

    // Reset in the middle of a preamble with three words queued.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, DW'(12'h7E1 + i));
    idleCycles(1'b1, 8);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    idleCycles(1'b1, 20);

    // Push during LOAD while three words are stored.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, DW'(12'h150 + i));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h999);
    checkOutput("load_level", 32'(fifo_level), 32'd3);
    checkOutput("load_overflow", 32'(overflow), 32'd0);
    idleCycles(1'b1, 4 * (FRAME + 2) + 4);

    // Randomised traffic, enable toggling and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 599) == 0),
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 39) == 0),
                    DW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
